serial_adder: RTL



---
 rtl/serial_adder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, carry FF, shift registers.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] nacc;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fs;
  logic             fc;
  logic             last;
  logic             load;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cy),
    .s  (fs),
    .co (fc)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign nacc = {fs, acc};
  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    nxt  = state;
    load = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt  = RUN;
          load = 1'b1;
        end else begin
          nxt  = IDLE;
        end
      end
      RUN: begin
        if (last) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      sa   <= a;
      sb   <= b;
      cy   <= cin;
      cnt  <= '0;
    end else if (busy) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      acc  <= nacc[WIDTH-1:1];
      cy   <= fc;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum  <= nacc;
        cout <= fc;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // cy holds the carry into the MSB during the final RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)              ovf <= 1'b0;
    else if (busy & last) ovf <= cy ^ fc;
  end
`endif

endmodule
